// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch path.
package riscv_pkg;

    // Canonical NOP (addi x0, x0, 0) presented to decode when nothing is queued.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] npc;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Two-entry instruction queue; entry 0 is always the head. Flush dominates push/pop.
module fetch_queue
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  if_id_t     wdata_i,
    output logic [1:0] count_o,
    output if_id_t     head_o
);

    if_id_t     mem_q [2];
    if_id_t     mem_d [2];
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       pop_eff;
    logic       push_eff;

    // Next-state: shift on pop, write behind the survivors on push.
    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        pop_eff  = pop_i && (count_q != 2'd0);
        push_eff = push_i && ((count_q != 2'd2) || pop_eff);
        if (flush_i) begin
            count_d = 2'd0;
        end else if (push_eff && pop_eff) begin
            if (count_q == 2'd1) begin
                mem_d[0] = wdata_i;
            end else begin
                mem_d[0] = mem_q[1];
                mem_d[1] = wdata_i;
            end
        end else if (push_eff) begin
            mem_d[count_q[0]] = wdata_i;
            count_d           = count_q + 2'd1;
        end else if (pop_eff) begin
            mem_d[0] = mem_q[1];
            count_d  = count_q - 2'd1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding memory requests, 2-entry queue to decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [31:0] IFID_instreg,
    output logic [63:0] IFID_npc,
    output logic        IFID_ready,
    input  logic        IDIF_stall,
    input  logic        EXIF_branch,
    input  logic [63:0] EXIF_target
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  npc_q, npc_d;
    logic [1:0]   q_count;
    if_id_t       q_head;
    if_id_t       q_wdata;
    logic         q_push;
    logic         q_pop;
    logic         req_fire;

    // Requests only from REQ with queue room; a redirect or reset cycle never issues.
    always_comb begin
        mem_req_valid = !reset && !EXIF_branch && (state_q == REQ) &&
                        (32'(q_count) < FIFO_DEPTH);
        mem_req_addr  = pc_q;
        req_fire      = mem_req_valid && mem_req_ready;
        IFID_ready    = (q_count != 2'd0);
        IFID_instreg  = IFID_ready ? q_head.inst : NOP_INSTR;
        IFID_npc      = IFID_ready ? q_head.npc : 64'h0;
        q_push        = !EXIF_branch && (state_q == WAIT) && mem_resp_valid;
        q_pop         = !EXIF_branch && IFID_ready && !IDIF_stall;
        q_wdata.inst  = mem_resp_data;
        q_wdata.npc   = npc_q;
    end

    // Next-state: redirect has priority; a response landing in the redirect cycle
    // retires the outstanding request, so no drain is needed then.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        if (reset) begin
            state_d = REQ;
            pc_d    = RESET_PC;
            npc_d   = 64'h0;
        end else if (EXIF_branch) begin
            pc_d    = EXIF_target & ~64'h3;
            state_d = ((state_q != REQ) && !mem_resp_valid) ? DRAIN : REQ;
        end else begin
            unique case (state_q)
                REQ: begin
                    if (req_fire) begin
                        pc_d    = pc_q + 64'd4;
                        npc_d   = pc_q + 64'd4;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) state_d = REQ;
                end
                DRAIN: begin
                    if (mem_resp_valid) state_d = REQ;
                end
                default: state_d = REQ;
            endcase
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        npc_q   <= npc_d;
    end

    fetch_queue u_queue (
        .clk     (clk),
        .reset   (reset),
        .flush_i (EXIF_branch),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .wdata_i (q_wdata),
        .count_o (q_count),
        .head_o  (q_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-outstanding responder memory.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [31:0] IFID_instreg;
    logic [63:0] IFID_npc;
    logic        IFID_ready;
    logic        IDIF_stall;
    logic        EXIF_branch;
    logic [63:0] EXIF_target;

    int errors = 0;
    int checks = 0;

    logic        pend;
    logic [63:0] pend_addr;
    logic        resp_en;
    int          req_cnt = 0;
    int          base;

    fetch_unit #(
        .RESET_PC   (64'h1000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .IFID_instreg   (IFID_instreg),
        .IFID_npc       (IFID_npc),
        .IFID_ready     (IFID_ready),
        .IDIF_stall     (IDIF_stall),
        .EXIF_branch    (EXIF_branch),
        .EXIF_target    (EXIF_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0000;
    endfunction

    // Memory: answers the single outstanding request whenever resp_en is high.
    assign mem_resp_valid = pend && resp_en;
    assign mem_resp_data  = word_of(pend_addr);

    always @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
        end else if (mem_req_valid && mem_req_ready) begin
            pend      <= 1'b1;
            pend_addr <= mem_req_addr;
            req_cnt   <= req_cnt + 1;
        end else if (mem_resp_valid) begin
            pend <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        mem_req_ready = 1'b1;
        IDIF_stall    = 1'b0;
        EXIF_branch   = 1'b0;
        EXIF_target   = 64'h0;
        resp_en       = 1'b1;
        pend          = 1'b0;
        pend_addr     = 64'h0;

        // Reset state
        step();
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_ready", 64'(IFID_ready), 64'd0);
        chk("rst_inst", 64'(IFID_instreg), 64'h13);
        chk("rst_npc", IFID_npc, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Streaming, no stall: one instruction every two cycles
        chk("s_c0_valid", 64'(mem_req_valid), 64'd1);
        chk("s_c0_addr", mem_req_addr, 64'h1000);
        step();
        chk("s_c1_ready", 64'(IFID_ready), 64'd0);
        step();
        chk("s_c2_ready", 64'(IFID_ready), 64'd1);
        chk("s_c2_npc", IFID_npc, 64'h1004);
        chk("s_c2_inst", 64'(IFID_instreg), 64'(word_of(64'h1000)));
        step();
        chk("s_c3_ready", 64'(IFID_ready), 64'd0);
        step();
        chk("s_c4_npc", IFID_npc, 64'h1008);
        step();
        chk("s_c5_ready", 64'(IFID_ready), 64'd0);
        step();
        chk("s_c6_npc", IFID_npc, 64'h100C);

        // Stall for 10 cycles: queue fills with exactly two requests
        IDIF_stall = 1'b1;
        do_reset();
        base = req_cnt;
        repeat (10) step();
        chk("st_reqs", 64'(req_cnt - base), 64'd2);
        chk("st_ready", 64'(IFID_ready), 64'd1);
        chk("st_head", IFID_npc, 64'h1004);
        IDIF_stall = 1'b0;
        #1;
        chk("st_pop0", IFID_npc, 64'h1004);
        step();
        chk("st_pop1_ready", 64'(IFID_ready), 64'd1);
        chk("st_pop1", IFID_npc, 64'h1008);

        // Redirect while WAIT: stale response dropped
        IDIF_stall = 1'b1;
        resp_en    = 1'b0;
        do_reset();
        chk("br_c0_addr", mem_req_addr, 64'h1000);
        step();
        EXIF_branch = 1'b1;
        EXIF_target = 64'h2003;
        #1;
        chk("br_c1_valid", 64'(mem_req_valid), 64'd0);
        step();
        EXIF_branch = 1'b0;
        resp_en     = 1'b1;
        #1;
        chk("br_drain_valid", 64'(mem_req_valid), 64'd0);
        chk("br_drain_ready", 64'(IFID_ready), 64'd0);
        step();
        chk("br_req_valid", 64'(mem_req_valid), 64'd1);
        chk("br_req_addr", mem_req_addr, 64'h2000);
        chk("br_req_ready", 64'(IFID_ready), 64'd0);
        step();
        step();
        chk("br_out_ready", 64'(IFID_ready), 64'd1);
        chk("br_out_npc", IFID_npc, 64'h2004);
        chk("br_out_inst", 64'(IFID_instreg), 64'(word_of(64'h2000)));

        // Redirect coinciding with a response and a pop
        step();
        IDIF_stall  = 1'b0;
        EXIF_branch = 1'b1;
        EXIF_target = 64'h3000;
        #1;
        chk("bp_resp_present", 64'(mem_resp_valid), 64'd1);
        chk("bp_ready_before", 64'(IFID_ready), 64'd1);
        chk("bp_valid_gated", 64'(mem_req_valid), 64'd0);
        step();
        EXIF_branch = 1'b0;
        #1;
        chk("bp_ready", 64'(IFID_ready), 64'd0);
        chk("bp_inst", 64'(IFID_instreg), 64'h13);
        chk("bp_npc", IFID_npc, 64'h0);
        chk("bp_next_addr", mem_req_addr, 64'h3000);

        // Memory not ready: request held stable
        mem_req_ready = 1'b0;
        base          = req_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("nr_valid", 64'(mem_req_valid), 64'd1);
            chk("nr_addr", mem_req_addr, 64'h3000);
        end
        chk("nr_no_accept", 64'(req_cnt - base), 64'd0);
        mem_req_ready = 1'b1;
        step();
        chk("nr_wait_valid", 64'(mem_req_valid), 64'd0);
        step();
        chk("nr_out_npc", IFID_npc, 64'h3004);

        // Reset while a request is outstanding and the queue holds an entry
        IDIF_stall = 1'b1;
        resp_en    = 1'b0;
        step();
        chk("rw_ready_before", 64'(IFID_ready), 64'd1);
        reset = 1'b1;
        #1;
        chk("rw_valid_in_reset", 64'(mem_req_valid), 64'd0);
        step();
        reset   = 1'b0;
        resp_en = 1'b1;
        #1;
        chk("rw_ready", 64'(IFID_ready), 64'd0);
        chk("rw_inst", 64'(IFID_instreg), 64'h13);
        chk("rw_valid", 64'(mem_req_valid), 64'd1);
        chk("rw_addr", mem_req_addr, 64'h1000);
        step();
        step();
        chk("rw_first_npc", IFID_npc, 64'h1004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
